hash_arbiter: RTL and testbench

Shares the single hash unit (64-bit key, 5-bit length, 10-bit hash) among several NDN lookup clients: PIT, CS and FIB name-prefix hashing. It accepts one request at a time through a round-robin grant. It drives the registered key and length into the hash unit, waits a fixed latency, and returns the hash tagged with the requester ID over a valid/ready handshake. It sits between the packet-parsing front end and the hash block.

---
 rtl/hash_arbiter_pkg.sv | 14 +
 rtl/hash_arbiter_if.sv | 28 ++
 rtl/hash_arbiter_rr_picker.sv | 24 ++
 rtl/hash_arbiter.sv | 87 ++++++++
 tb/tb_hash_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_arbiter_pkg.sv
// hash_arbiter_pkg: shared widths, requester indices and FSM encoding for the hash arbiter.
package hash_arbiter_pkg;
    localparam int HASH_KEY_W = 64;
    localparam int HASH_LEN_W = 5;
    localparam int HASH_OUT_W = 10;
    localparam int REQ_PIT = 0;
    localparam int REQ_CS  = 1;
    localparam int REQ_FIB = 2;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/hash_arbiter_if.sv
// hash_arbiter_if: requester, hash-unit and response signals of the hash arbiter.
interface hash_arbiter_if
    import hash_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*HASH_KEY_W-1:0] req_data;
    logic [NUM_REQ*HASH_LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]            req_ready;
    logic [HASH_KEY_W-1:0]         hash_data;
    logic [HASH_LEN_W-1:0]         hash_len;
    logic [HASH_OUT_W-1:0]         hash_result;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [HASH_OUT_W-1:0]         resp_hash;
    logic [ID_W-1:0]               resp_id;
    logic                          busy;
    modport slave (
        input  req_valid, req_data, req_len, hash_result, resp_ready,
        output req_ready, hash_data, hash_len, resp_valid, resp_hash, resp_id, busy
    );
    modport master (
        output req_valid, req_data, req_len, hash_result, resp_ready,
        input  req_ready, hash_data, hash_len, resp_valid, resp_hash, resp_id, busy
    );
endinterface

// File: rtl/hash_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector, first valid index above last.
module rr_picker #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    logic [ID_W-1:0] pos;
    always_comb begin
        idx = '0;
        pos = '0;
        // Walk from farthest to nearest so the nearest valid index wins.
        for (int k = N; k >= 1; k--) begin
            pos = ID_W'((int'(last) + k) % N);
            if (valid[pos]) idx = pos;
        end
        any   = |valid;
        grant = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin sharing of one fixed-latency hash unit among NDN lookup clients.
module hash_arbiter
    import hash_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ID_W         = 2,
    parameter int HASH_LATENCY = 1
) (
    input logic          clk,
    input logic          rst,
    hash_arbiter_if.slave bus
);
    state_t                state_q, state_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [HASH_KEY_W-1:0] hash_data_q, hash_data_d;
    logic [HASH_LEN_W-1:0] hash_len_q, hash_len_d;
    logic [HASH_OUT_W-1:0] resp_hash_q, resp_hash_d;
    logic [ID_W-1:0]       resp_id_q, resp_id_d;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       winner;
    logic                  any_valid;

    rr_picker #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid(bus.req_valid),
        .last (last_q),
        .grant(grant),
        .idx  (winner),
        .any  (any_valid)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        hash_data_d = hash_data_q;
        hash_len_d  = hash_len_q;
        resp_hash_d = resp_hash_q;
        resp_id_d   = resp_id_q;
        case (state_q)
            IDLE: if (any_valid) begin
                hash_data_d = bus.req_data[int'(winner)*HASH_KEY_W +: HASH_KEY_W];
                hash_len_d  = bus.req_len[int'(winner)*HASH_LEN_W +: HASH_LEN_W];
                last_d      = winner;
                cnt_d       = 3'(HASH_LATENCY);
                state_d     = HOLD;
            end
            HOLD: if (cnt_q == '0) begin
                resp_hash_d = bus.hash_result;
                resp_id_d   = last_q;
                state_d     = RESP;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            RESP: state_d = bus.resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            hash_data_q <= '0;
            hash_len_q  <= '0;
            resp_hash_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            hash_data_q <= hash_data_d;
            hash_len_q  <= hash_len_d;
            resp_hash_q <= resp_hash_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) ? grant : '0;
    assign bus.hash_data  = hash_data_q;
    assign bus.hash_len   = hash_len_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_hash  = resp_hash_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed and randomized checks of hash_arbiter against a transaction-level model.
module tb_hash_arbiter;
    import hash_arbiter_pkg::*;
    localparam int N  = 3;
    localparam int IW = 2;
    localparam int L  = 1;
    localparam int L2 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();
    hash_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus2 ();

    hash_arbiter #(.NUM_REQ(N), .ID_W(IW), .HASH_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    hash_arbiter #(.NUM_REQ(N), .ID_W(IW), .HASH_LATENCY(L2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic logic [9:0] hashf(input logic [63:0] k, input logic [4:0] n);
        logic [9:0] h;
        h = 10'(n) * 10'd37;
        for (int i = 0; i < 7; i++) h = h ^ 10'(k >> (10 * i));
        return h;
    endfunction

    // Behavioural hash unit: result appears L clocks after its inputs.
    logic [9:0] p1 [L];
    logic [9:0] p2 [L2];
    always @(posedge clk) begin
        p1[0] <= hashf(bus.hash_data, bus.hash_len);
        for (int i = 1; i < L; i++) p1[i] <= p1[i-1];
        p2[0] <= hashf(bus2.hash_data, bus2.hash_len);
        for (int i = 1; i < L2; i++) p2[i] <= p2[i-1];
    end

    logic [N-1:0] v = '0;
    logic [63:0]  d [N];
    logic [4:0]   ln [N];
    logic         rr = 1'b0;
    logic [N-1:0] v2 = '0;
    assign bus.req_valid   = v;
    assign bus.hash_result = p1[L-1];
    assign bus.resp_ready  = rr;
    assign bus2.req_valid   = v2;
    assign bus2.req_data    = {{2{64'h0}}, 64'hDEAD_BEEF_0123_4567};
    assign bus2.req_len     = {10'h0, 5'd17};
    assign bus2.hash_result = p2[L2-1];
    assign bus2.resp_ready  = 1'b1;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_data[64*i +: 64] = d[i];
            bus.req_len[5*i +: 5]    = ln[i];
        end
    end

    int total = 0;
    int bad   = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a transaction is accepted, its response is due L+2 cycles later, and it is retired on handshake.
    int         cyc = 0;
    int         due = 0;
    bit         m_busy = 0;
    bit         m_resp = 0;
    int         m_last = N - 1;
    int         m_id = 0;
    logic [9:0] m_hash = '0;
    logic [63:0] m_hd = '0;
    logic [4:0] m_hl = '0;
    bit         rearm [N];
    int         gq [$];
    int         rq [$];
    int         rcnt1 = 0;

    task automatic step();
        logic [N-1:0] er;
        logic [N-1:0] g;
        int w;
        @(negedge clk);
        er = '0;
        w = -1;
        if (!m_busy && v != '0)
            for (int k = 1; k <= N; k++)
                if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("resp_valid", 64'(bus.resp_valid), 64'(m_resp));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("hash_data", bus.hash_data, m_hd);
        chk("hash_len", 64'(bus.hash_len), 64'(m_hl));
        if (m_resp) begin
            chk("resp_hash", 64'(bus.resp_hash), 64'(m_hash));
            chk("resp_id", 64'(bus.resp_id), 64'(m_id));
        end
        g = bus.req_ready;
        for (int i = 0; i < N; i++) if (g[i]) gq.push_back(i);
        if (bus.resp_valid && rr) rq.push_back(int'(bus.resp_id));
        if (bus.resp_valid && bus.resp_id == 2'd1) rcnt1++;
        if (w >= 0) begin
            m_hd = d[w]; m_hl = ln[w]; m_last = w; m_id = w;
            m_hash = hashf(d[w], ln[w]);
            m_busy = 1; due = cyc + L + 2;
        end else if (m_resp && rr) begin
            m_resp = 0; m_busy = 0;
        end else if (m_busy && !m_resp && cyc + 1 == due) begin
            m_resp = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (g[i] && !rearm[i]) v[i] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rv(input int max);
        for (int i = 0; i < max && !bus.resp_valid; i++) step();
        chk("rv_wait", 64'(bus.resp_valid), 64'd1);
    endtask

    task automatic do_reset();
        v = '0;
        v2 = '0;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hash_data", bus.hash_data, 64'd0);
        chk("rst_hash_len", 64'(bus.hash_len), 64'd0);
        chk("rst_resp_hash", 64'(bus.resp_hash), 64'd0);
        chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
        m_busy = 0; m_resp = 0; m_last = N - 1; m_hd = '0; m_hl = '0;
        for (int i = 0; i < N; i++) rearm[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp6 [6];
        int n;
        exp6 = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < N; i++) begin d[i] = '0; ln[i] = '0; rearm[i] = 0; end
        do_reset();

        // Single request from PIT.
        d[REQ_PIT] = 64'h1; ln[REQ_PIT] = 5'd1; v = 3'b001; rr = 1'b1;
        run(6);

        // All three requesters held valid continuously.
        do_reset();
        rr = 1'b1;
        d[REQ_PIT] = 64'h2; ln[REQ_PIT] = 5'd2;
        d[REQ_CS]  = 64'h3; ln[REQ_CS]  = 5'd2;
        d[REQ_FIB] = 64'hA5; ln[REQ_FIB] = 5'd8;
        for (int i = 0; i < N; i++) rearm[i] = 1;
        v = 3'b111;
        gq.delete(); rq.delete();
        run(24);
        for (int i = 0; i < N; i++) rearm[i] = 0;
        v = '0;
        run(6);
        chk("grant_count", 64'(gq.size() >= 6), 64'd1);
        chk("resp_count", 64'(rq.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("grant_order", 64'(gq[i]), 64'(exp6[i]));
        for (int i = 0; i < 6 && i < rq.size(); i++) chk("resp_order", 64'(rq[i]), 64'(exp6[i]));

        // Backpressure with CS waiting behind PIT.
        do_reset();
        rr = 1'b0;
        d[REQ_PIT] = 64'h1234; ln[REQ_PIT] = 5'd9;
        d[REQ_CS]  = 64'h5678; ln[REQ_CS]  = 5'd3;
        v = 3'b011;
        step();
        gq.delete();
        wait_rv(10);
        run(10);
        chk("bp_no_grant", 64'(gq.size()), 64'd0);
        rr = 1'b1;
        run(2);
        chk("bp_cs_granted", 64'(gq.size() > 0 && gq[0] == REQ_CS), 64'd1);
        run(5);

        // Reset while a request is in HOLD.
        do_reset();
        rr = 1'b1;
        d[REQ_PIT] = 64'hCAFE; ln[REQ_PIT] = 5'd4; v = 3'b001;
        step();
        step();
        rq.delete();
        do_reset();
        d[REQ_FIB] = 64'hFEED; ln[REQ_FIB] = 5'd31; v = 3'b100;
        wait_rv(10);
        chk("post_rst_id", 64'(bus.resp_id), 64'(REQ_FIB));
        run(3);
        chk("post_rst_resps", 64'(rq.size()), 64'd1);

        // CS withdraws before being granted.
        do_reset();
        rr = 1'b1;
        d[REQ_PIT] = 64'h77; ln[REQ_PIT] = 5'd7; v = 3'b001;
        step();
        d[REQ_CS] = 64'h99; ln[REQ_CS] = 5'd5; v[REQ_CS] = 1'b1;
        step();
        v[REQ_CS] = 1'b0;
        rcnt1 = 0;
        run(10);
        chk("no_cs_resp", 64'(rcnt1), 64'd0);

        // Latency-3 build: response 5 cycles after acceptance.
        do_reset();
        v2 = 3'b001;
        @(negedge clk);
        chk("l3_ready", 64'(bus2.req_ready), 64'd1);
        @(posedge clk);
        #1;
        v2 = '0;
        for (n = 1; n < 20; n++) begin
            @(negedge clk);
            if (bus2.resp_valid) break;
        end
        chk("l3_latency", 64'(n), 64'd5);
        chk("l3_hash", 64'(bus2.resp_hash), 64'(hashf(64'hDEAD_BEEF_0123_4567, 5'd17)));
        chk("l3_id", 64'(bus2.resp_id), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(2) == 0) begin
                    v[i] = 1'b1; d[i] = {$urandom, $urandom}; ln[i] = 5'($urandom);
                end else if (v[i] && $urandom_range(15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            rr = ($urandom_range(3) != 0);
        end
        v = '0;
        rr = 1'b1;
        run(12);
        chk("idle_end", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
